fp_mul_iter: RTL and testbench

FP_MUL_ITER -- requirements
Module: fp_mul_iter

---
 rtl/fp_mul_pkg.sv | 25 ++
 rtl/fp_mul_round.sv | 71 +++++++
 rtl/fp_mul_iter.sv | 221 ++++++++++++++++++++++
 tb/tb_fp_mul_iter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared definitions for the iterative floating-point multiplier.
//   state_e : controller states
//   Rnd*    : rnd_mode encodings
//   Flag*   : bit positions within the 4-bit flags vector
package fp_mul_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StNorm,
    StRnd,
    StDone
  } state_e;

  localparam logic [1:0] RndRne = 2'b00;
  localparam logic [1:0] RndRtz = 2'b01;
  localparam logic [1:0] RndPos = 2'b10;
  localparam logic [1:0] RndNeg = 2'b11;

  localparam int unsigned FlagInvalid   = 3;
  localparam int unsigned FlagOverflow  = 2;
  localparam int unsigned FlagUnderflow = 1;
  localparam int unsigned FlagInexact   = 0;

endpackage

// File: rtl/fp_mul_round.sv
// Combinational rounding and packing stage.
//   sign_i     : result sign
//   exp_i      : signed biased exponent of the normalised significand
//   mant_i     : stored mantissa bits (hidden bit excluded)
//   guard_i, round_i, sticky_i : discarded-bit summary
//   rnd_mode_i : rounding mode
//   result_o   : packed result; flags_o : {invalid, overflow, underflow, inexact}
module fp_mul_round
  import fp_mul_pkg::*;
#(
  parameter int unsigned E_WIDTH = 8,
  parameter int unsigned M_WIDTH = 23,
  localparam int unsigned D_WIDTH = 1 + E_WIDTH + M_WIDTH,
  localparam int unsigned XW = E_WIDTH + 2
) (
  input  logic                  sign_i,
  input  logic signed [XW-1:0]  exp_i,
  input  logic [M_WIDTH-1:0]    mant_i,
  input  logic                  guard_i,
  input  logic                  round_i,
  input  logic                  sticky_i,
  input  logic [1:0]            rnd_mode_i,
  output logic [D_WIDTH-1:0]    result_o,
  output logic [3:0]            flags_o
);

  localparam logic signed [XW-1:0] ExpMax  = XW'((1 << E_WIDTH) - 1);
  localparam logic signed [XW-1:0] ExpZero = '0;

  logic                 inexact;
  logic                 up;
  logic                 away;
  logic [M_WIDTH:0]     mant_sum;
  logic signed [XW-1:0] exp_fin;

  always_comb begin
    inexact = guard_i | round_i | sticky_i;
    case (rnd_mode_i)
      RndRne:  up = guard_i & (round_i | sticky_i | mant_i[0]);
      RndRtz:  up = 1'b0;
      RndPos:  up = ~sign_i & inexact;
      default: up = sign_i & inexact;
    endcase
    // Directional mode that moves the magnitude away from zero for this sign.
    away = ((rnd_mode_i == RndPos) & ~sign_i) | ((rnd_mode_i == RndNeg) & sign_i);

    // A carry out of the mantissa leaves it all-zero, i.e. 1.0 at the next exponent.
    mant_sum = {1'b0, mant_i} + {{M_WIDTH{1'b0}}, up};
    exp_fin  = exp_i + {{(XW-1){1'b0}}, mant_sum[M_WIDTH]};

    result_o = {sign_i, exp_fin[E_WIDTH-1:0], mant_sum[M_WIDTH-1:0]};
    flags_o  = '0;
    flags_o[FlagInexact] = inexact;

    if (exp_fin >= ExpMax) begin
      flags_o[FlagOverflow] = 1'b1;
      flags_o[FlagInexact]  = 1'b1;
      if ((rnd_mode_i == RndRne) || away) begin
        result_o = {sign_i, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
      end else begin
        result_o = {sign_i, {(E_WIDTH-1){1'b1}}, 1'b0, {M_WIDTH{1'b1}}};
      end
    end else if (exp_fin <= ExpZero) begin
      // Flush to zero: no subnormal outputs.
      flags_o[FlagUnderflow] = 1'b1;
      flags_o[FlagInexact]   = 1'b1;
      result_o = {sign_i, {(D_WIDTH-1){1'b0}}};
    end
  end

endmodule

// File: rtl/fp_mul_iter.sv
// Iterative floating-point multiplier with valid/ready handshakes.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready only while idle)
//   floating1_in/2_in     : operands {sign, exp, mantissa}
//   rnd_mode              : 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf
//   out_valid / out_ready : result handshake; result and flags hold while out_valid
//   floating_multiplication_out, flags : product and {invalid, overflow, underflow, inexact}
module fp_mul_iter
  import fp_mul_pkg::*;
#(
  parameter int unsigned E_WIDTH = 8,
  parameter int unsigned M_WIDTH = 23,
  localparam int unsigned D_WIDTH = 1 + E_WIDTH + M_WIDTH,
  localparam int unsigned BIAS = (1 << (E_WIDTH - 1)) - 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] floating1_in,
  input  logic [D_WIDTH-1:0] floating2_in,
  input  logic [1:0]         rnd_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] floating_multiplication_out,
  output logic [3:0]         flags
);

  localparam int unsigned W    = M_WIDTH + 1;
  localparam int unsigned XW   = E_WIDTH + 2;
  localparam int unsigned CntW = $clog2(M_WIDTH + 1);
  localparam logic [CntW-1:0]    LastCnt = CntW'(M_WIDTH);
  localparam logic [D_WIDTH-1:0] QNaN    =
      {1'b0, {E_WIDTH{1'b1}}, 1'b1, {(M_WIDTH-1){1'b0}}};

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [W-1:0]         a_q, a_d;
  logic [2*W-1:0]       prod_q, prod_d;
  logic signed [XW-1:0] exp_q, exp_d;
  logic                 sign_q, sign_d;
  logic [1:0]           mode_q, mode_d;
  logic [M_WIDTH-1:0]   mant_q, mant_d;
  logic                 g_q, g_d, r_q, r_d, s_q, s_d;
  logic [D_WIDTH-1:0]   res_q, res_d;
  logic [3:0]           flags_q, flags_d;

  // Operand decode
  logic               sign_a, sign_b;
  logic [E_WIDTH-1:0] exp_a, exp_b;
  logic [M_WIDTH-1:0] man_a, man_b;
  logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;
  logic special;
  logic [D_WIDTH-1:0] spec_res;
  logic [3:0]         spec_flags;
  logic signed [XW-1:0] exp_start;

  assign {sign_a, exp_a, man_a} = floating1_in;
  assign {sign_b, exp_b, man_b} = floating2_in;

  always_comb begin
    zero_a  = (exp_a == '0);
    zero_b  = (exp_b == '0);
    inf_a   = (&exp_a) & ~(|man_a);
    inf_b   = (&exp_b) & ~(|man_b);
    nan_a   = (&exp_a) & (|man_a);
    nan_b   = (&exp_b) & (|man_b);
    snan_a  = nan_a & ~man_a[M_WIDTH-1];
    snan_b  = nan_b & ~man_b[M_WIDTH-1];
    special = zero_a | zero_b | (&exp_a) | (&exp_b);

    spec_flags = '0;
    if (nan_a | nan_b) begin
      spec_res = QNaN;
      spec_flags[FlagInvalid] = snan_a | snan_b;
    end else if ((inf_a & zero_b) | (inf_b & zero_a)) begin
      spec_res = QNaN;
      spec_flags[FlagInvalid] = 1'b1;
    end else if (inf_a | inf_b) begin
      spec_res = {sign_a ^ sign_b, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
    end else begin
      // Exponent-zero operands (including denormals) act as signed zero.
      spec_res = {sign_a ^ sign_b, {(D_WIDTH-1){1'b0}}};
    end

    exp_start = {2'b00, exp_a} + {2'b00, exp_b} - XW'(BIAS);
  end

  // Shift-add step: add multiplicand to the upper half when the multiplier LSB is set,
  // then shift the whole accumulator/multiplier right by one.
  logic [W:0] mac_sum;
  assign mac_sum = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, a_q} : '0);

  // Product in [1,4): the MSB tells whether a 1-bit normalising shift is needed.
  logic msb;
  assign msb = prod_q[2*W-1];

  logic [D_WIDTH-1:0] rnd_res;
  logic [3:0]         rnd_flags;

  fp_mul_round #(
    .E_WIDTH (E_WIDTH),
    .M_WIDTH (M_WIDTH)
  ) u_round (
    .sign_i     (sign_q),
    .exp_i      (exp_q),
    .mant_i     (mant_q),
    .guard_i    (g_q),
    .round_i    (r_q),
    .sticky_i   (s_q),
    .rnd_mode_i (mode_q),
    .result_o   (rnd_res),
    .flags_o    (rnd_flags)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    prod_d  = prod_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    mode_d  = mode_q;
    mant_d  = mant_q;
    g_d     = g_q;
    r_d     = r_q;
    s_d     = s_q;
    res_d   = res_q;
    flags_d = flags_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d = sign_a ^ sign_b;
          mode_d = rnd_mode;
          exp_d  = exp_start;
          a_d    = {1'b1, man_a};
          prod_d = {{W{1'b0}}, 1'b1, man_b};
          cnt_d  = '0;
          if (special) begin
            res_d   = spec_res;
            flags_d = spec_flags;
            state_d = StDone;
          end else begin
            state_d = StMul;
          end
        end
      end
      StMul: begin
        prod_d = {mac_sum, prod_q[W-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StNorm;
        end
      end
      StNorm: begin
        exp_d = exp_q + {{(XW-1){1'b0}}, msb};
        if (msb) begin
          mant_d = prod_q[2*M_WIDTH:M_WIDTH+1];
          g_d    = prod_q[M_WIDTH];
          r_d    = prod_q[M_WIDTH-1];
          s_d    = |prod_q[M_WIDTH-2:0];
        end else begin
          mant_d = prod_q[2*M_WIDTH-1:M_WIDTH];
          g_d    = prod_q[M_WIDTH-1];
          r_d    = prod_q[M_WIDTH-2];
          s_d    = |prod_q[M_WIDTH-3:0];
        end
        state_d = StRnd;
      end
      StRnd: begin
        res_d   = rnd_res;
        flags_d = rnd_flags;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      prod_q  <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      mode_q  <= '0;
      mant_q  <= '0;
      g_q     <= 1'b0;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      prod_q  <= prod_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      mode_q  <= mode_d;
      mant_q  <= mant_d;
      g_q     <= g_d;
      r_q     <= r_d;
      s_q     <= s_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready                    = (state_q == StIdle);
  assign out_valid                   = (state_q == StDone);
  assign floating_multiplication_out = res_q;
  assign flags                       = flags_q;

endmodule

// File: tb/tb_fp_mul_iter.sv
module tb_fp_mul_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] floating1_in = '0;
  logic [31:0] floating2_in = '0;
  logic [1:0]  rnd_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] floating_multiplication_out;
  logic [3:0]  flags;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_mul_iter #(
    .E_WIDTH (8),
    .M_WIDTH (23)
  ) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .in_valid                    (in_valid),
    .in_ready                    (in_ready),
    .floating1_in                (floating1_in),
    .floating2_in                (floating2_in),
    .rnd_mode                    (rnd_mode),
    .out_valid                   (out_valid),
    .out_ready                   (out_ready),
    .floating_multiplication_out (floating_multiplication_out),
    .flags                       (flags)
  );

  // Reference: exact integer product, rounded by comparing the remainder against half an ulp.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] m, output logic [31:0] r,
                                  output logic [3:0] f);
    int ea, eb, e, sh;
    longint unsigned ma, mb, p, q, rem, half;
    bit s, inx, up, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'(a[22:0]);
    mb = longint'(b[22:0]);
    a_nan  = (ea == 255) && (ma != 0);
    b_nan  = (eb == 255) && (mb != 0);
    a_snan = a_nan && !a[22];
    b_snan = b_nan && !b[22];
    a_inf  = (ea == 255) && (ma == 0);
    b_inf  = (eb == 255) && (mb == 0);
    if (a_nan || b_nan) begin
      r = 32'h7FC00000;
      f = (a_snan || b_snan) ? 4'b1000 : 4'b0000;
      return;
    end
    if ((a_inf && eb == 0) || (b_inf && ea == 0)) begin
      r = 32'h7FC00000;
      f = 4'b1000;
      return;
    end
    if (a_inf || b_inf) begin
      r = {s, 8'hFF, 23'h0};
      f = 4'b0000;
      return;
    end
    if (ea == 0 || eb == 0) begin
      r = {s, 31'h0};
      f = 4'b0000;
      return;
    end
    p = (ma | (64'd1 << 23)) * (mb | (64'd1 << 23));
    e = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e++;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    inx  = (rem != 0);
    case (m)
      2'b00:   up = (rem > half) || ((rem == half) && q[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = !s && inx;
      default: up = s && inx;
    endcase
    q = q + longint'(up);
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) begin
      f = 4'b0101;
      if (m == 2'b00 || (m == 2'b10 && !s) || (m == 2'b11 && s)) r = {s, 8'hFF, 23'h0};
      else r = {s, 8'hFE, 23'h7FFFFF};
    end else if (e <= 0) begin
      r = {s, 31'h0};
      f = 4'b0011;
    end else begin
      r = {s, 8'(e), q[22:0]};
      f = {3'b000, inx};
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 15);
    if (k == 0) v[30:23] = 8'h00;
    else if (k == 1) v[30:23] = 8'hFF;
    else if (k == 2) begin
      v[30:23] = 8'hFF;
      v[22:0]  = '0;
    end else if (k < 13) v[30:23] = 8'($urandom_range(96, 158));
    return v;
  endfunction

  function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF)
      return 1;
    return 27;
  endfunction

  // Issue one operation, wait (bounded) for the result, then accept it.
  // lat counts cycles with 1 = the cycle right after the accepting edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                       output logic [31:0] r, output logic [3:0] f, output int lat);
    @(negedge clk);
    floating1_in = a;
    floating2_in = b;
    rnd_mode     = m;
    in_valid     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = floating_multiplication_out;
    f = flags;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (floating_multiplication_out !== 32'h0) begin
      n_err++;
      $display("FAIL reset_out: got %h want 00000000", floating_multiplication_out);
    end
    n_cmp++;
    if (flags !== 4'h0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000", flags);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta[7] = '{32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h7F000000,
                           32'h7F000000, 32'h00800000, 32'h7F800000};
    logic [31:0] tb[7] = '{32'h40000000, 32'h3F800001, 32'h3F800001, 32'h7F000000,
                           32'h7F000000, 32'h3F000000, 32'h00000000};
    logic [1:0]  tm[7] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
    logic [31:0] tr[7] = '{32'h40400000, 32'h3F800002, 32'h3F800003, 32'h7F800000,
                           32'h7F7FFFFF, 32'h00000000, 32'h7FC00000};
    logic [3:0]  tf[7] = '{4'b0000, 4'b0001, 4'b0001, 4'b0101, 4'b0101, 4'b0011, 4'b1000};
    int          tl[7] = '{27, 27, 27, 27, 27, 27, 1};
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      do_op(ta[i], tb[i], tm[i], r, f, lat);
      n_cmp++;
      if (r !== tr[i]) begin
        n_err++;
        $display("FAIL directed_%0d_result: got %h want %h", i, r, tr[i]);
      end
      n_cmp++;
      if (f !== tf[i]) begin
        n_err++;
        $display("FAIL directed_%0d_flags: got %b want %b", i, f, tf[i]);
      end
      n_cmp++;
      if (lat != tl[i]) begin
        n_err++;
        $display("FAIL directed_%0d_latency: got %0d want %0d", i, lat, tl[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, er;
    logic [3:0]  f, ef;
    logic [1:0]  m;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      a = rand_op();
      b = rand_op();
      m = 2'($urandom_range(0, 3));
      ref_mul(a, b, m, er, ef);
      do_op(a, b, m, r, f, lat);
      n_cmp++;
      if (r !== er) begin
        n_err++;
        $display("FAIL random_result: %h x %h mode %0d got %h want %h", a, b, m, r, er);
      end
      n_cmp++;
      if (f !== ef) begin
        n_err++;
        $display("FAIL random_flags: %h x %h mode %0d got %b want %b", a, b, m, f, ef);
      end
      n_cmp++;
      if (lat != exp_latency(a, b)) begin
        n_err++;
        $display("FAIL random_latency: %h x %h got %0d want %0d", a, b, lat,
                 exp_latency(a, b));
      end
    end
  endtask

  // New operands offered while busy must not disturb the in-flight operation.
  task automatic test_busy_ignore();
    logic [31:0] er;
    logic [3:0]  ef;
    int          lat;
    bit          rdy_seen;
    ref_mul(32'h40490FDB, 32'hC0000000, 2'b00, er, ef);
    @(negedge clk);
    floating1_in = 32'h40490FDB;
    floating2_in = 32'hC0000000;
    rnd_mode     = 2'b00;
    in_valid     = 1'b1;
    @(posedge clk);
    #1;
    floating1_in = 32'h3F800000;
    floating2_in = 32'h3F800000;
    rnd_mode     = 2'b01;
    rdy_seen     = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (rdy_seen !== 1'b0) begin
      n_err++;
      $display("FAIL busy_in_ready: got ready while busy, want never");
    end
    n_cmp++;
    if (floating_multiplication_out !== er || flags !== ef) begin
      n_err++;
      $display("FAIL busy_result: got %h/%b want %h/%b", floating_multiplication_out, flags,
               er, ef);
    end
    n_cmp++;
    if (lat != 27) begin
      n_err++;
      $display("FAIL busy_latency: got %0d want 27", lat);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Backpressure, then an operand already waiting at the handshake edge.
  task automatic test_back_to_back();
    logic [31:0] er, er2, r0;
    logic [3:0]  ef, ef2, f0;
    int          lat;
    bit          stable;
    ref_mul(32'hBFA00000, 32'h41200000, 2'b11, er, ef);
    ref_mul(32'h3F812345, 32'h3FFEDCBA, 2'b10, er2, ef2);
    @(negedge clk);
    floating1_in = 32'hBFA00000;
    floating2_in = 32'h41200000;
    rnd_mode     = 2'b11;
    in_valid     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r0 = floating_multiplication_out;
    f0 = flags;
    n_cmp++;
    if (r0 !== er || f0 !== ef) begin
      n_err++;
      $display("FAIL hold_result: got %h/%b want %h/%b", r0, f0, er, ef);
    end
    // Next operand is presented while the result is still being held.
    floating1_in = 32'h3F812345;
    floating2_in = 32'h3FFEDCBA;
    rnd_mode     = 2'b10;
    in_valid     = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || floating_multiplication_out !== r0 || flags !== f0)
        stable = 1'b0;
    end
    n_cmp++;
    if (stable !== 1'b1) begin
      n_err++;
      $display("FAIL hold_stable: got unstable output or ready while held, want stable");
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL handshake_idle: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_cmp++;
    if (lat != 27 || floating_multiplication_out !== er2 || flags !== ef2) begin
      n_err++;
      $display("FAIL back_to_back: got %h/%b lat %0d want %h/%b lat 27",
               floating_multiplication_out, flags, lat, er2, ef2);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, er;
    logic [3:0]  f, ef;
    int          lat;
    bit          seen;
    @(negedge clk);
    floating1_in = 32'h40000000;
    floating2_in = 32'h40400000;
    rnd_mode     = 2'b00;
    in_valid     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || floating_multiplication_out !== 32'h0 || flags !== 4'h0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got valid=%b out=%h flags=%b want 0/0/0", out_valid,
               floating_multiplication_out, flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_ready: got %b want 1", in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_no_output: got out_valid after reset, want none");
    end
    ref_mul(32'h40000000, 32'h40400000, 2'b00, er, ef);
    do_op(32'h40000000, 32'h40400000, 2'b00, r, f, lat);
    n_cmp++;
    if (r !== er || f !== ef || lat != 27) begin
      n_err++;
      $display("FAIL reset_mid_recover: got %h/%b lat %0d want %h/%b lat 27", r, f, lat, er,
               ef);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
